// File: rtl/cipher_add_ctrl.sv
// Block sequencer for the PASTA keystream/plaintext adder.
// Latency: 5 cycles per block (FETCH, ADD, WAIT x2, OUT); Done one cycle after the last OUT handshake.
// Backpressure: operand fetch waits on KsValid/PtxtValid; ciphertext is held in OUT until CtxtReady.
module cipher_add_ctrl #(
  parameter int S      = 32,
  parameter int BITLEN = 17,
  parameter int CNT_W  = 16
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Start_SI,
  input  logic [CNT_W-1:0]      NumBlocks_DI,
  output logic                  Busy_SO,
  output logic                  Done_SO,
  output logic [CNT_W-1:0]      BlockIdx_DO,
  output logic                  KsReq_SO,
  input  logic                  KsValid_SI,
  input  logic [S*BITLEN-1:0]   KsData_DI,
  input  logic                  PtxtValid_SI,
  output logic                  PtxtReady_SO,
  input  logic [S*BITLEN-1:0]   PtxtData_DI,
  output logic                  AddStart_SO,
  output logic [S*BITLEN-1:0]   AddPtxt_DO,
  output logic [S*BITLEN-1:0]   AddKey_DO,
  input  logic                  AddFinish_SI,
  input  logic [S*BITLEN-1:0]   AddData_DI,
  output logic                  CtxtValid_SO,
  input  logic                  CtxtReady_SI,
  output logic [S*BITLEN-1:0]   CtxtData_DO
);

  localparam int DW = S * BITLEN;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ADD   = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    ks_q, ks_d;
  logic [DW-1:0]    pt_q, pt_d;
  logic [DW-1:0]    ctxt_q, ctxt_d;
  logic             ks_full_q, ks_full_d;
  logic             pt_full_q, pt_full_d;
  logic             ks_cap, pt_cap;

  // State and datapath registers; reset discards any in-flight block.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      idx_q     <= '0;
      ks_q      <= '0;
      pt_q      <= '0;
      ctxt_q    <= '0;
      ks_full_q <= 1'b0;
      pt_full_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      ks_q      <= ks_d;
      pt_q      <= pt_d;
      ctxt_q    <= ctxt_d;
      ks_full_q <= ks_full_d;
      pt_full_q <= pt_full_d;
    end
  end

  // Next-state logic and state-decoded outputs; data outputs are zero outside their window.
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    idx_d        = idx_q;
    ks_d         = ks_q;
    pt_d         = pt_q;
    ctxt_d       = ctxt_q;
    ks_full_d    = ks_full_q;
    pt_full_d    = pt_full_q;
    ks_cap       = 1'b0;
    pt_cap       = 1'b0;
    Done_SO      = 1'b0;
    KsReq_SO     = 1'b0;
    PtxtReady_SO = 1'b0;
    AddStart_SO  = 1'b0;
    AddPtxt_DO   = '0;
    AddKey_DO    = '0;
    CtxtValid_SO = 1'b0;
    CtxtData_DO  = '0;

    case (state_q)
      S_IDLE: begin
        if (Start_SI) begin
          num_d     = NumBlocks_DI;
          idx_d     = '0;
          ks_full_d = 1'b0;
          pt_full_d = 1'b0;
          state_d   = (NumBlocks_DI == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        // Each operand is requested only until it has been captured once.
        KsReq_SO     = ~ks_full_q;
        PtxtReady_SO = ~pt_full_q;
        ks_cap       = ~ks_full_q & KsValid_SI;
        pt_cap       = ~pt_full_q & PtxtValid_SI;
        if (ks_cap) begin
          ks_d      = KsData_DI;
          ks_full_d = 1'b1;
        end
        if (pt_cap) begin
          pt_d      = PtxtData_DI;
          pt_full_d = 1'b1;
        end
        if (ks_full_d && pt_full_d) begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        AddStart_SO = 1'b1;
        AddPtxt_DO  = pt_q;
        AddKey_DO   = ks_q;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // Operands stay on the adder inputs until it reports completion.
        AddPtxt_DO = pt_q;
        AddKey_DO  = ks_q;
        if (AddFinish_SI) begin
          ctxt_d  = AddData_DI;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        CtxtValid_SO = 1'b1;
        CtxtData_DO  = ctxt_q;
        if (CtxtReady_SI) begin
          // num_q is nonzero here, so num_q-1 never underflows and idx never wraps.
          if (idx_q == num_q - CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + CNT_W'(1);
            ks_full_d = 1'b0;
            pt_full_d = 1'b0;
            state_d   = S_FETCH;
          end
        end
      end
      S_DONE: begin
        Done_SO   = 1'b1;
        idx_d     = '0;
        ks_full_d = 1'b0;
        pt_full_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Busy_SO     = (state_q != S_IDLE);
  assign BlockIdx_DO = idx_q;

endmodule

// File: tb/tb_cipher_add_ctrl.sv
// Directed bench for cipher_add_ctrl with a 2-cycle behavioural adder.
// Expected values are hand-derived cycle numbers and word-wise sums.
// Ciphertext backpressure is driven from a fixed ready pattern.
module tb_cipher_add_ctrl;

  localparam int S      = 32;
  localparam int BITLEN = 17;
  localparam int CNT_W  = 16;
  localparam int DW     = S * BITLEN;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_blocks = '0;
  logic             busy, done;
  logic [CNT_W-1:0] blk_idx;
  logic             ks_req;
  logic             ks_vld = 1'b0;
  logic [DW-1:0]    ks_dat = '0;
  logic             pt_vld = 1'b0;
  logic             pt_rdy;
  logic [DW-1:0]    pt_dat = '0;
  logic             add_start;
  logic [DW-1:0]    add_ptxt, add_key;
  logic             add_finish;
  logic [DW-1:0]    add_data;
  logic             ct_vld;
  logic             ct_rdy = 1'b0;
  logic [DW-1:0]    ct_dat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cipher_add_ctrl #(.S(S), .BITLEN(BITLEN), .CNT_W(CNT_W)) dut (
    .Clk_CI       (clk),
    .Rst_RI       (rst),
    .Start_SI     (start),
    .NumBlocks_DI (num_blocks),
    .Busy_SO      (busy),
    .Done_SO      (done),
    .BlockIdx_DO  (blk_idx),
    .KsReq_SO     (ks_req),
    .KsValid_SI   (ks_vld),
    .KsData_DI    (ks_dat),
    .PtxtValid_SI (pt_vld),
    .PtxtReady_SO (pt_rdy),
    .PtxtData_DI  (pt_dat),
    .AddStart_SO  (add_start),
    .AddPtxt_DO   (add_ptxt),
    .AddKey_DO    (add_key),
    .AddFinish_SI (add_finish),
    .AddData_DI   (add_data),
    .CtxtValid_SO (ct_vld),
    .CtxtReady_SI (ct_rdy),
    .CtxtData_DO  (ct_dat)
  );

  function automatic logic [DW-1:0] fill(input int unsigned w);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < S; i++) r[i*BITLEN +: BITLEN] = BITLEN'(w);
    return r;
  endfunction

  function automatic logic [DW-1:0] add_words(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < S; i++) r[i*BITLEN +: BITLEN] = a[i*BITLEN +: BITLEN] + b[i*BITLEN +: BITLEN];
    return r;
  endfunction

  // Behavioural adder: Finish two cycles after the Start cycle; stray_fin injects a spurious Finish.
  logic [1:0]    add_sr = 2'b00;
  logic [DW-1:0] add_res = '0;
  logic          stray_fin = 1'b0;
  always @(posedge clk) begin
    add_sr <= {add_sr[0], add_start};
    if (add_start) add_res <= add_words(add_key, add_ptxt);
  end
  assign add_finish = add_sr[1] | stray_fin;
  assign add_data   = add_res;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_idx"}, blk_idx, 0);
    check({tag, "_ksreq"}, ks_req, 0);
    check({tag, "_ptrdy"}, pt_rdy, 0);
    check({tag, "_addst"}, add_start, 0);
    check({tag, "_addpt"}, add_ptxt, 0);
    check({tag, "_addkey"}, add_key, 0);
    check({tag, "_ctvld"}, ct_vld, 0);
    check({tag, "_ctdat"}, ct_dat, 0);
  endtask

  // One-block message with all handshakes open; Ks=1s, Ptxt=2s, result=3s.
  task automatic run_one(input string tag);
    ks_dat = fill(1); pt_dat = fill(2);
    ks_vld = 1'b1; pt_vld = 1'b1; ct_rdy = 1'b1;
    num_blocks = 16'd1; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      check($sformatf("%s_addst_c%0d", tag, c), add_start, (c == 2));
      check($sformatf("%s_ctvld_c%0d", tag, c), ct_vld, (c == 5));
      check($sformatf("%s_done_c%0d", tag, c), done, (c == 6));
      check($sformatf("%s_busy_c%0d", tag, c), busy, (c >= 1 && c <= 6));
      if (c == 1) check({tag, "_ksreq"}, ks_req, 1);
      if (c == 3) check({tag, "_addkey"}, add_key, fill(1));
      if (c == 4) check({tag, "_addpt"}, add_ptxt, fill(2));
      if (c == 5) begin
        check({tag, "_ctdat"}, ct_dat, fill(3));
        check({tag, "_idx"}, blk_idx, 0);
      end
    end
  endtask

  initial begin
    int n_add, n_done, out_cnt, pt_cnt;
    bit pt_hs_prev, finished;
    logic [15:0] pat;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("rst");

    // Single block
    tick();
    run_one("t1");

    // Three blocks with ciphertext backpressure
    tick();
    pat = 16'b1001_0100_0110_0010;
    n_add = 0; n_done = 0; out_cnt = 0; pt_cnt = 0; pt_hs_prev = 0; finished = 0;
    ks_dat = fill(5); pt_dat = fill(100);
    ks_vld = 1'b1; pt_vld = 1'b1; ct_rdy = pat[0];
    num_blocks = 16'd3; start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (pt_hs_prev) begin
        pt_cnt++;
        pt_dat = fill(100 + pt_cnt);
      end
      pt_hs_prev = pt_rdy & pt_vld;
      if (add_start) n_add++;
      ct_rdy = pat[c % 16];
      if (ct_vld) begin
        check($sformatf("t2_ctdat_c%0d", c), ct_dat, fill(105 + out_cnt));
        check($sformatf("t2_idx_c%0d", c), blk_idx, out_cnt);
        if (ct_rdy) out_cnt++;
      end
      if (done) begin
        n_done++;
        finished = 1;
        break;
      end
    end
    check("t2_finished", finished, 1);
    check("t2_n_add", n_add, 3);
    check("t2_n_out", out_cnt, 3);
    check("t2_n_done", n_done, 1);
    tick();
    check("t2_idle_idx", blk_idx, 0);
    check("t2_idle_done", done, 0);

    // Skewed operands: plaintext valid from cycle 1, keystream valid from cycle 5
    ks_dat = fill(7); pt_dat = fill(9);
    ks_vld = 1'b0; pt_vld = 1'b1; ct_rdy = 1'b1;
    num_blocks = 16'd1; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 5) ks_vld = 1'b1;
      check($sformatf("t3_ptrdy_c%0d", c), pt_rdy, (c == 1));
      check($sformatf("t3_ksreq_c%0d", c), ks_req, (c <= 5));
      check($sformatf("t3_addst_c%0d", c), add_start, (c == 6));
      check($sformatf("t3_ctvld_c%0d", c), ct_vld, (c == 9));
      check($sformatf("t3_done_c%0d", c), done, (c == 10));
      if (c == 9) check("t3_ctdat", ct_dat, fill(16));
    end

    // Zero-length message
    tick();
    ks_vld = 1'b1; pt_vld = 1'b1;
    num_blocks = 16'd0; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      check($sformatf("t4_done_c%0d", c), done, (c == 1));
      check($sformatf("t4_busy_c%0d", c), busy, (c == 1));
      check($sformatf("t4_ksreq_c%0d", c), ks_req, 0);
      check($sformatf("t4_ptrdy_c%0d", c), pt_rdy, 0);
      check($sformatf("t4_addst_c%0d", c), add_start, 0);
      check($sformatf("t4_ctvld_c%0d", c), ct_vld, 0);
    end

    // Start pulses during WAIT and OUT are ignored
    ks_dat = fill(20); pt_dat = fill(30); ct_rdy = 1'b1;
    num_blocks = 16'd2; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = (c == 3 || c == 4 || c == 5 || c == 8 || c == 9 || c == 10);
      num_blocks = start ? 16'd7 : 16'd2;
      check($sformatf("t5_ctvld_c%0d", c), ct_vld, (c == 5 || c == 10));
      check($sformatf("t5_done_c%0d", c), done, (c == 11));
      check($sformatf("t5_busy_c%0d", c), busy, (c <= 11));
      if (c == 5) begin
        check("t5_idx0", blk_idx, 0);
        check("t5_dat0", ct_dat, fill(50));
      end
      if (c == 10) begin
        check("t5_idx1", blk_idx, 1);
        check("t5_dat1", ct_dat, fill(50));
      end
    end
    start = 1'b0;

    // Reset during WAIT of block index 1, stray Finish afterwards, then a clean restart
    tick();
    ks_dat = fill(1); pt_dat = fill(2); ct_rdy = 1'b1;
    num_blocks = 16'd3; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 8) begin
        check("t6_idx_wait", blk_idx, 1);
        rst = 1'b1;
      end
      if (c == 9) rst = 1'b0;
    end
    check_all_zero("t6_rst");
    for (int c = 10; c <= 12; c++) begin
      tick();
      stray_fin = (c == 10);
      check($sformatf("t6_stray_ctvld_c%0d", c), ct_vld, 0);
      check($sformatf("t6_stray_busy_c%0d", c), busy, 0);
    end
    stray_fin = 1'b0;
    tick();
    run_one("t6_restart");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
